// File: rtl/vga_sig_gen.sv
// VGA display stage: 640x480@60 timing from a pixel-rate enable, 4x-scaled
// 1-bit frame buffer readout, per-frame colour latch and sync generation.
module vga_sig_gen #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_VIS    = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_VIS    = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] CONFIG_COLOURS,
    output logic [14:0] FB_ADDR,
    input  logic        FB_DATA,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic [7:0]  VGA_DATA,
    output logic        FRAME_START
);

    localparam int unsigned H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_FIRST = H_VIS + H_FP;
    localparam int unsigned HS_LAST  = H_VIS + H_FP + H_SYNC - 1;
    localparam int unsigned VS_FIRST = V_VIS + V_FP;
    localparam int unsigned VS_LAST  = V_VIS + V_FP + V_SYNC - 1;
    localparam int unsigned CNT_W    = 10;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned COL_W    = 8;
    localparam int unsigned ROW_W    = 7;
    localparam int unsigned ADR_W    = 15;

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;
    logic             tick_c;

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             h_last_c;
    logic             v_last_c;
    logic             frame_wrap_c;

    logic             visible_c;
    logic             hs_act_c;
    logic             vs_act_c;
    logic [COL_W-1:0] pixel_c;

    logic [COL_W-1:0] fg;
    logic [COL_W-1:0] bg;

    // Pixel tick on the last CLK of each divider period
    always_comb begin
        tick_c  = (div == DIV_W'(CLK_DIV - 1));
        div_nxt = div + DIV_W'(1);
        if (tick_c) begin
            div_nxt = '0;
        end
    end

    // Divider register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            div <= '0;
        end else begin
            div <= div_nxt;
        end
    end

    // Next raster position; V advances only when H wraps
    always_comb begin
        h_last_c     = (h_cnt == CNT_W'(H_TOTAL - 1));
        v_last_c     = (v_cnt == CNT_W'(V_TOTAL - 1));
        frame_wrap_c = tick_c & h_last_c & v_last_c;
        h_nxt        = h_cnt;
        v_nxt        = v_cnt;
        if (tick_c) begin
            if (h_last_c) begin
                h_nxt = '0;
                if (v_last_c) begin
                    v_nxt = '0;
                end else begin
                    v_nxt = v_cnt + CNT_W'(1);
                end
            end else begin
                h_nxt = h_cnt + CNT_W'(1);
            end
        end
    end

    // Raster counters
    always_ff @(posedge CLK) begin
        if (RESET) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    // Decode of the current position: visibility, sync windows, FB address
    always_comb begin
        visible_c = (h_cnt < CNT_W'(H_VIS)) && (v_cnt < CNT_W'(V_VIS));
        hs_act_c  = (h_cnt >= CNT_W'(HS_FIRST)) && (h_cnt <= CNT_W'(HS_LAST));
        vs_act_c  = (v_cnt >= CNT_W'(VS_FIRST)) && (v_cnt <= CNT_W'(VS_LAST));
        FB_ADDR   = '0;
        if (visible_c) begin
            FB_ADDR = ADR_W'({v_cnt[ROW_W+1:2], h_cnt[CNT_W-1:2]});
        end
    end

    // Colour selection; FB_DATA is only looked at inside the visible area
    always_comb begin
        pixel_c = '0;
        if (visible_c) begin
            pixel_c = FB_DATA ? fg : bg;
        end
    end

    // Output stage, one pixel behind the counters
    always_ff @(posedge CLK) begin
        if (RESET) begin
            VGA_HS   <= ~SYNC_POL;
            VGA_VS   <= ~SYNC_POL;
            VGA_DATA <= '0;
        end else if (tick_c) begin
            VGA_HS   <= hs_act_c ? SYNC_POL : ~SYNC_POL;
            VGA_VS   <= vs_act_c ? SYNC_POL : ~SYNC_POL;
            VGA_DATA <= pixel_c;
        end
    end

    // Colours latched once per frame so a mid-frame change cannot tear
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fg <= '0;
            bg <= '0;
        end else if (frame_wrap_c) begin
            fg <= CONFIG_COLOURS[15:8];
            bg <= CONFIG_COLOURS[7:0];
        end
    end

    // Frame start strobe, coincident with the counters entering (0,0)
    always_ff @(posedge CLK) begin
        if (RESET) begin
            FRAME_START <= 1'b0;
        end else begin
            FRAME_START <= frame_wrap_c;
        end
    end

endmodule

// File: tb/tb_vga_sig_gen.sv
// Bench for vga_sig_gen: full-size instance for line timing, addressing and
// mid-line reset; a reduced-raster instance for frame-level behaviour.
module tb_vga_sig_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Full-size instance
    logic        rst_d = 1'b1;
    logic [15:0] cfg_d = 16'h0000;
    logic [14:0] addr_d;
    logic        fb_data_d = 1'b0;
    logic        hs_d, vs_d, fs_d;
    logic [7:0]  data_d;

    // Reduced raster: 16x12 visible, line 24, frame 16 lines
    localparam int SH_TOT = 24;
    localparam int SV_TOT = 16;
    localparam int S_FRAME = SH_TOT * SV_TOT;
    logic        rst_s = 1'b1;
    logic [15:0] cfg_s = 16'hFA05;
    logic [14:0] addr_s;
    logic        fb_data_s = 1'b0;
    logic        hs_s, vs_s, fs_s;
    logic [7:0]  data_s;
    int          fb_mode = 0;

    vga_sig_gen dut (
        .CLK(clk), .RESET(rst_d), .CONFIG_COLOURS(cfg_d), .FB_ADDR(addr_d),
        .FB_DATA(fb_data_d), .VGA_HS(hs_d), .VGA_VS(vs_d), .VGA_DATA(data_d),
        .FRAME_START(fs_d)
    );

    vga_sig_gen #(
        .CLK_DIV(4), .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_VIS(12), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
    ) dut_s (
        .CLK(clk), .RESET(rst_s), .CONFIG_COLOURS(cfg_s), .FB_ADDR(addr_s),
        .FB_DATA(fb_data_s), .VGA_HS(hs_s), .VGA_VS(vs_s), .VGA_DATA(data_s),
        .FRAME_START(fs_s)
    );

    // mode 0: all ones, 1: all zeros, 2: only address 0x0102 set
    function automatic logic fb_bit(input logic [14:0] a, input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'b0;
        return (a == 15'h0102);
    endfunction

    // Frame-buffer pattern per frame of the reduced raster
    function automatic int mode_of(input int f);
        if (f == 2) return 1;
        if (f == 3) return 2;
        return 0;
    endfunction

    // Expected FB address from raster position
    function automatic logic [14:0] exp_addr(input int h, input int v, input int hv, input int vv);
        logic [14:0] a;
        a = 15'h0;
        if (h < hv && v < vv) a = {7'(v >> 2), 8'(h >> 2)};
        return a;
    endfunction

    // Synchronous RAM models
    always @(posedge clk) fb_data_d <= ^addr_d;
    always @(posedge clk) fb_data_s <= fb_bit(addr_s, fb_mode);

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++; if (hs_d !== 1'b1) begin fails++; $display("FAIL rst_hs_d: got %b want 1", hs_d); end
        tests++; if (vs_d !== 1'b1) begin fails++; $display("FAIL rst_vs_d: got %b want 1", vs_d); end
        tests++; if (data_d !== 8'h00) begin fails++; $display("FAIL rst_data_d: got %h want 00", data_d); end
        tests++; if (addr_d !== 15'h0) begin fails++; $display("FAIL rst_addr_d: got %h want 0000", addr_d); end
        tests++; if (fs_d !== 1'b0) begin fails++; $display("FAIL rst_fs_d: got %b want 0", fs_d); end
        tests++; if (hs_s !== 1'b1) begin fails++; $display("FAIL rst_hs_s: got %b want 1", hs_s); end
        tests++; if (vs_s !== 1'b1) begin fails++; $display("FAIL rst_vs_s: got %b want 1", vs_s); end
        tests++; if (data_s !== 8'h00) begin fails++; $display("FAIL rst_data_s: got %h want 00", data_s); end
        tests++; if (fs_s !== 1'b0) begin fails++; $display("FAIL rst_fs_s: got %b want 0", fs_s); end
    endtask

    // Line timing, sync levels and addressing on the full-size raster
    task automatic test_line_timing();
        int fall1 = -1;
        int rise1 = -1;
        int fall2 = -1;
        logic hs_prev = 1'b1;
        logic exp_hs;
        logic [14:0] ea;
        int k, p, h, v;
        @(negedge clk) rst_d = 1'b0;
        for (int n = 1; n <= 4 * 6404; n++) begin
            @(posedge clk); #1;
            if (hs_prev && !hs_d) begin
                if (fall1 < 0) fall1 = n; else if (fall2 < 0) fall2 = n;
            end
            if (!hs_prev && hs_d && rise1 < 0) rise1 = n;
            hs_prev = hs_d;
            if (n % 4 == 0) begin
                k = n / 4;
                p = k - 1;
                h = p % 800;
                v = (p / 800) % 525;
                exp_hs = (h >= 656 && h <= 751) ? 1'b0 : 1'b1;
                tests++; if (hs_d !== exp_hs) begin fails++; $display("FAIL line_hs tick %0d: got %b want %b", k, hs_d, exp_hs); end
                tests++; if (vs_d !== 1'b1) begin fails++; $display("FAIL line_vs tick %0d: got %b want 1", k, vs_d); end
                tests++; if (data_d !== 8'h00) begin fails++; $display("FAIL line_data tick %0d: got %h want 00", k, data_d); end
                ea = exp_addr(k % 800, k / 800, 640, 480);
                tests++; if (addr_d !== ea) begin fails++; $display("FAIL line_addr tick %0d: got %h want %h", k, addr_d, ea); end
                if (k == 8 * 800 + 4) begin
                    tests++; if (addr_d !== 15'h0201) begin fails++; $display("FAIL addr_h4_v8: got %h want 0201", addr_d); end
                end
                if (k == 639) begin
                    tests++; if (addr_d !== 15'h009F) begin fails++; $display("FAIL addr_h639_v0: got %h want 009f", addr_d); end
                end
                if (k == 640) begin
                    tests++; if (addr_d !== 15'h0000) begin fails++; $display("FAIL addr_h640: got %h want 0000", addr_d); end
                end
            end
        end
        tests++; if (fall1 != 2628) begin fails++; $display("FAIL hs_first_edge: got %0d want 2628", fall1); end
        tests++; if (rise1 - fall1 != 384) begin fails++; $display("FAIL hs_width: got %0d want 384", rise1 - fall1); end
        tests++; if (fall2 - fall1 != 3200) begin fails++; $display("FAIL hs_period: got %0d want 3200", fall2 - fall1); end
    endtask

    // One-CLK reset inside the HS pulse (counters at H=700, V=8)
    task automatic test_reset_mid();
        int fall = -1;
        logic hs_prev = 1'b1;
        repeat (4 * 7100 - 4 * 6404) @(posedge clk);
        #1;
        tests++; if (hs_d !== 1'b0) begin fails++; $display("FAIL pre_reset_hs: got %b want 0", hs_d); end
        @(negedge clk) rst_d = 1'b1;
        @(posedge clk); #1;
        tests++; if (hs_d !== 1'b1) begin fails++; $display("FAIL mid_rst_hs: got %b want 1", hs_d); end
        tests++; if (vs_d !== 1'b1) begin fails++; $display("FAIL mid_rst_vs: got %b want 1", vs_d); end
        tests++; if (data_d !== 8'h00) begin fails++; $display("FAIL mid_rst_data: got %h want 00", data_d); end
        tests++; if (addr_d !== 15'h0) begin fails++; $display("FAIL mid_rst_addr: got %h want 0000", addr_d); end
        tests++; if (fs_d !== 1'b0) begin fails++; $display("FAIL mid_rst_fs: got %b want 0", fs_d); end
        @(negedge clk) rst_d = 1'b0;
        for (int n = 1; n <= 3000 && fall < 0; n++) begin
            @(posedge clk); #1;
            if (hs_prev && !hs_d) fall = n;
            hs_prev = hs_d;
        end
        tests++; if (fall != 2628) begin fails++; $display("FAIL restart_hs_edge: got %0d want 2628", fall); end
    endtask

    // Frame behaviour: VS, colour latch, FB patterns, FRAME_START
    task automatic test_frames();
        logic [15:0] lat = 16'h0000;
        logic exp_hs, exp_vs, exp_fs, bit_v;
        logic [7:0] exp_d;
        logic [14:0] ea;
        int k, p, h, v, f;
        @(negedge clk) rst_s = 1'b0;
        for (int n = 1; n <= 6 * S_FRAME * 4 + 160; n++) begin
            @(posedge clk); #1;
            exp_fs = (n % (S_FRAME * 4) == 0);
            tests++; if (fs_s !== exp_fs) begin fails++; $display("FAIL frame_start clk %0d: got %b want %b", n, fs_s, exp_fs); end
            if (n % 4 == 0) begin
                k = n / 4;
                if (k % S_FRAME == 0) begin
                    lat = cfg_s;
                    fb_mode = mode_of(k / S_FRAME);
                end
                if (k == 4 * S_FRAME + 6 * SH_TOT) cfg_s = 16'h3C00;
                p = k - 1;
                h = p % SH_TOT;
                v = (p / SH_TOT) % SV_TOT;
                f = p / S_FRAME;
                exp_hs = (h >= 18 && h <= 21) ? 1'b0 : 1'b1;
                exp_vs = (v >= 13 && v <= 14) ? 1'b0 : 1'b1;
                case (mode_of(f))
                    0: bit_v = 1'b1;
                    1: bit_v = 1'b0;
                    default: bit_v = (h >= 8 && h <= 11 && v >= 4 && v <= 7);
                endcase
                exp_d = 8'h00;
                if (h < 16 && v < 12) exp_d = bit_v ? lat[15:8] : lat[7:0];
                tests++; if (hs_s !== exp_hs) begin fails++; $display("FAIL fr_hs p %0d: got %b want %b", p, hs_s, exp_hs); end
                tests++; if (vs_s !== exp_vs) begin fails++; $display("FAIL fr_vs p %0d: got %b want %b", p, vs_s, exp_vs); end
                tests++; if (data_s !== exp_d) begin fails++; $display("FAIL fr_data p %0d (h %0d v %0d f %0d): got %h want %h", p, h, v, f, data_s, exp_d); end
                ea = exp_addr(k % SH_TOT, (k / SH_TOT) % SV_TOT, 16, 12);
                tests++; if (addr_s !== ea) begin fails++; $display("FAIL fr_addr tick %0d: got %h want %h", k, addr_s, ea); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_reset_mid();
        test_frames();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
